// File: rtl/parking_lot_ctrl.sv
// parking_lot_ctrl: lot occupancy counter with independent entry/exit gate sequencers.
//   clk, reset        : clock, synchronous active-high reset
//   entry_req_i       : entry kiosk request (level)
//   exit_req_i        : exit kiosk request (level)
//   enter_pulse_i     : one-cycle pulse, car completed entry
//   exit_pulse_i      : one-cycle pulse, car completed exit
//   gate_in_open_o    : entry gate open command (registered)
//   gate_out_open_o   : exit gate open command (registered)
//   occupancy_o       : cars currently in the lot
//   full_o, empty_o   : occupancy == CAPACITY / occupancy == 0
//   reject_o          : one-cycle pulse, entry refused because the lot is full
//   timeout_o         : one-cycle pulses, [1] exit gate / [0] entry gate timed out
//   err_ovf_o         : sticky, enter pulse while full
//   err_unf_o         : sticky, exit pulse while empty
// Optional feature, enabled by defining PARKING_PEAK_TRACK_EN:
//   peak_clr_i        : load peak with the current occupancy
//   peak_o            : maximum occupancy since reset / last clear
module parking_lot_ctrl #(
  parameter int CAPACITY = 16,
  parameter int GATE_CYCLES = 50,
  parameter int HOLDOFF = 4,
  localparam int CW = $clog2(CAPACITY + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          entry_req_i,
  input  logic          exit_req_i,
  input  logic          enter_pulse_i,
  input  logic          exit_pulse_i,
`ifdef PARKING_PEAK_TRACK_EN
  input  logic          peak_clr_i,
  output logic [CW-1:0] peak_o,
`endif
  output logic          gate_in_open_o,
  output logic          gate_out_open_o,
  output logic [CW-1:0] occupancy_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          reject_o,
  output logic [1:0]    timeout_o,
  output logic          err_ovf_o,
  output logic          err_unf_o
);
  typedef enum logic [1:0] {IDLE, OPEN, HOLD} gate_state_e;
  localparam int TW = $clog2(GATE_CYCLES + HOLDOFF + 1);
  logic [CW-1:0] occ_q, occ_d;
  logic ovf_q, unf_q, rej_q, inc, dec;
  logic [1:0] prev_q, req, pulse, blk, open_w, to_w, idle_w;
  assign full_o = occ_q == CW'(CAPACITY);
  assign empty_o = occ_q == '0;
  assign inc = enter_pulse_i & ~exit_pulse_i;
  assign dec = exit_pulse_i & ~enter_pulse_i;
  assign occ_d = (inc & ~full_o) ? occ_q + CW'(1) : (dec & ~empty_o) ? occ_q - CW'(1) : occ_q;
  // index 0 is the entry gate, index 1 the exit gate; only entry is blocked by capacity
  assign req = {exit_req_i, entry_req_i};
  assign pulse = {exit_pulse_i, enter_pulse_i};
  assign blk = {1'b0, full_o};
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      rej_q <= 1'b0;
      prev_q <= '0;
    end else begin
      occ_q <= occ_d;
      ovf_q <= ovf_q | (inc & full_o);
      unf_q <= unf_q | (dec & empty_o);
      prev_q <= req;
      // refusal fires only on the rising edge of a request seen while idle and blocked
      rej_q <= |(idle_w & req & ~prev_q & blk);
    end
  end
  for (genvar g = 0; g < 2; g++) begin : gate
    gate_state_e st_q;
    logic [TW-1:0] tmr_q;
    logic open_q, to_q;
    always_ff @(posedge clk) begin
      if (reset) begin
        st_q <= IDLE;
        tmr_q <= '0;
        open_q <= 1'b0;
        to_q <= 1'b0;
      end else begin
        to_q <= 1'b0;
        case (st_q)
          IDLE: if (req[g] && !blk[g]) begin
            st_q <= OPEN;
            tmr_q <= TW'(GATE_CYCLES - 1);
            open_q <= 1'b1;
          end
          // a car pulse on the last open cycle wins over the timeout
          OPEN: if (pulse[g] || tmr_q == '0) begin
            st_q <= HOLD;
            tmr_q <= TW'(HOLDOFF - 1);
            open_q <= 1'b0;
            to_q <= ~pulse[g];
          end else tmr_q <= tmr_q - TW'(1);
          default: if (tmr_q == '0) st_q <= IDLE; else tmr_q <= tmr_q - TW'(1);
        endcase
      end
    end
    assign open_w[g] = open_q;
    assign to_w[g] = to_q;
    assign idle_w[g] = st_q == IDLE;
  end
`ifdef PARKING_PEAK_TRACK_EN
  logic [CW-1:0] peak_q;
  always_ff @(posedge clk) begin
    if (reset) peak_q <= '0;
    else peak_q <= (peak_clr_i || occ_d > peak_q) ? occ_d : peak_q;
  end
  assign peak_o = peak_q;
`endif
  assign gate_in_open_o = open_w[0];
  assign gate_out_open_o = open_w[1];
  assign occupancy_o = occ_q;
  assign reject_o = rej_q;
  assign timeout_o = to_w;
  assign err_ovf_o = ovf_q;
  assign err_unf_o = unf_q;
endmodule
